// File: rtl/sipo_pkg.sv
// Shared definitions for the serial/parallel converter family: output-stage
// state encoding and the bit-order shift step.
package sipo_pkg;

  localparam int unsigned SR_MAX_W = 64;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // One shift step on a register of 'width' live bits held in the low end of
  // a SR_MAX_W vector. The result is masked so callers can truncate freely.
  function automatic logic [SR_MAX_W-1:0] shift_step(
    input logic [SR_MAX_W-1:0] sr,
    input logic                b,
    input logic                msb_first,
    input int unsigned         width
  );
    logic [SR_MAX_W-1:0] mask;
    logic [SR_MAX_W-1:0] r;
    mask = (width >= SR_MAX_W) ? '1 : ((SR_MAX_W'(1) << width) - SR_MAX_W'(1));
    if (msb_first) r = {sr[SR_MAX_W-2:0], b};
    else           r = (sr >> 1) | (SR_MAX_W'(b) << (width - 1));
    return r & mask;
  endfunction

endpackage

// File: rtl/sipo_out_stage.sv
// One-entry holding register with valid/ready handshake and sticky overrun.
module sipo_out_stage
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             flush,
  input  logic             out_ready,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  output logic             overrun
);

  out_state_e state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= OUT_EMPTY;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (flush) overrun <= 1'b0;
      case (state)
        OUT_EMPTY: begin
          if (load) begin
            parallel_out <= word;
            out_valid    <= 1'b1;
            state        <= OUT_FULL;
          end
        end
        OUT_FULL: begin
          if (out_ready) begin
            if (load) begin
              parallel_out <= word;
            end else begin
              out_valid <= 1'b0;
              state     <= OUT_EMPTY;
            end
          end else if (load) begin
            // Consumer stalled: keep the held word, drop the new one.
            overrun <= 1'b1;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= OUT_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Parametrised serial-in/parallel-out deserializer with bit-count framing
// and a one-entry valid/ready output stage.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CNT_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             serial_in,
  input  logic             shift,
  input  logic             flush,
  output logic [WIDTH-1:0] parallel_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_nxt;
  logic             take;
  logic             complete;

  assign sr_nxt   = WIDTH'(shift_step(SR_MAX_W'(sr), serial_in, MSB_FIRST, WIDTH));
  // A flushed strobe is discarded, so it can never complete a word.
  assign take     = shift & ~flush;
  assign complete = take & (bit_count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (flush) begin
      sr        <= '0;
      bit_count <= '0;
    end else if (take) begin
      sr        <= sr_nxt;
      bit_count <= complete ? '0 : bit_count + CNT_W'(1);
    end
  end

  sipo_out_stage #(.WIDTH(WIDTH)) u_out (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (complete),
    .word         (sr_nxt),
    .flush        (flush),
    .out_ready    (out_ready),
    .parallel_out (parallel_out),
    .out_valid    (out_valid),
    .overrun      (overrun)
  );

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench: MSB-first and LSB-first 8-bit instances plus a 12-bit
// instance, all driven from one shared stimulus stream.
module tb_sipo_deser;

  logic clk = 1'b0;
  logic reset_n, serial_in, shift, flush, out_ready;

  logic [7:0]  po_m, po_l;
  logic [11:0] po_w;
  logic        ov_m, ov_l, ov_w;
  logic        vl_m, vl_l, vl_w;
  logic [2:0]  bc_m, bc_l;
  logic [3:0]  bc_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .shift(shift), .flush(flush),
    .parallel_out(po_m), .out_valid(vl_m), .out_ready(out_ready), .bit_count(bc_m), .overrun(ov_m));

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .shift(shift), .flush(flush),
    .parallel_out(po_l), .out_valid(vl_l), .out_ready(out_ready), .bit_count(bc_l), .overrun(ov_l));

  sipo_deser #(.WIDTH(12), .MSB_FIRST(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .serial_in(serial_in), .shift(shift), .flush(flush),
    .parallel_out(po_w), .out_valid(vl_w), .out_ready(out_ready), .bit_count(bc_w), .overrun(ov_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift bits w[n-1]..w[0] on consecutive cycles; gap>0 inserts random idle cycles.
  task automatic send(input logic [15:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      serial_in = w[i];
      shift     = 1'b1;
      step();
      shift = 1'b0;
      if (gap > 0) repeat ($urandom_range(0, gap)) step();
    end
    shift = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    reset_n = 1'b0; serial_in = 1'b0; shift = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst_po", {24'd0, po_m}, 32'h0);
    chk("rst_vld", {31'd0, vl_m}, 32'h0);
    chk("rst_bc", {29'd0, bc_m}, 32'h0);
    chk("rst_ov", {31'd0, ov_m}, 32'h0);
    reset_n = 1'b1;
    step();

    // Bit order, bit counter stepping
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) begin
      serial_in = pat[i];
      shift     = 1'b1;
      step();
      chk("t1_bc", {29'd0, bc_m}, 32'((8 - i) % 8));
    end
    shift = 1'b0;
    chk("t1_po_msb", {24'd0, po_m}, 32'hB2);
    chk("t1_vld", {31'd0, vl_m}, 32'h1);
    chk("t2_po_lsb", {24'd0, po_l}, 32'h4D);
    chk("t1_w_bc", {28'd0, bc_w}, 32'd8);
    out_ready = 1'b1;
    step();
    chk("t1_accept", {31'd0, vl_m}, 32'h0);
    out_ready = 1'b0;

    // Same bits with idle gaps between strobes
    send(16'h00B2, 8, 2);
    chk("t2_gap_msb", {24'd0, po_m}, 32'hB2);
    chk("t2_gap_lsb", {24'd0, po_l}, 32'h4D);
    chk("t2_gap_vld", {31'd0, vl_l}, 32'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Overrun
    send(16'h00B2, 8, 0);
    chk("t3_first", {24'd0, po_m}, 32'hB2);
    chk("t3_no_ov", {31'd0, ov_m}, 32'h0);
    send(16'h005A, 8, 0);
    chk("t3_hold", {24'd0, po_m}, 32'hB2);
    chk("t3_ov", {31'd0, ov_m}, 32'h1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_drain_vld", {31'd0, vl_m}, 32'h0);
    chk("t3_ov_sticky", {31'd0, ov_m}, 32'h1);
    chk("t3_po_kept", {24'd0, po_m}, 32'hB2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3_flush_ov", {31'd0, ov_m}, 32'h0);

    // Back-to-back: ready rises in the same cycle as the next completion
    send(16'h00A5, 8, 0);
    chk("t4_a5", {24'd0, po_m}, 32'hA5);
    send(16'h001E, 7, 0);           // upper 7 bits of 3C
    chk("t4_hold_vld", {31'd0, vl_m}, 32'h1);
    serial_in = 1'b0;
    shift     = 1'b1;
    out_ready = 1'b1;
    step();
    shift = 1'b0;
    chk("t4_b2b_vld", {31'd0, vl_m}, 32'h1);
    chk("t4_3c", {24'd0, po_m}, 32'h3C);
    chk("t4_no_ov", {31'd0, ov_m}, 32'h0);
    step();
    chk("t4_empty", {31'd0, vl_m}, 32'h0);

    // Flush mid-word, flush wins over a same-cycle strobe
    send(16'h0007, 3, 0);
    serial_in = 1'b1; shift = 1'b1; flush = 1'b1;
    step();
    shift = 1'b0; flush = 1'b0;
    chk("t5_bc0", {29'd0, bc_m}, 32'h0);
    send(16'h0014, 5, 0);           // A5 upper 5 bits
    chk("t5_no_word", {31'd0, vl_m}, 32'h0);
    chk("t5_bc5", {29'd0, bc_m}, 32'd5);
    send(16'h0005, 3, 0);
    chk("t5_a5", {24'd0, po_m}, 32'hA5);
    chk("t5_vld", {31'd0, vl_m}, 32'h1);

    // Asynchronous reset mid-word with a held word
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send(16'h00B2, 8, 0);
    send(16'h0015, 5, 0);
    chk("t6_pre_vld", {31'd0, vl_m}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_po", {24'd0, po_m}, 32'h0);
    chk("t6_async_vld", {31'd0, vl_m}, 32'h0);
    chk("t6_async_bc", {29'd0, bc_m}, 32'h0);
    step();
    reset_n = 1'b1;
    send(16'h00FF, 8, 0);
    chk("t6_ff", {24'd0, po_m}, 32'hFF);

    // 12-bit instance
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    send(16'h0ABC, 12, 0);
    chk("t6_w12", {20'd0, po_w}, 32'hABC);
    chk("t6_w12_vld", {31'd0, vl_w}, 32'h1);
    chk("t6_w12_bc", {28'd0, bc_w}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
